// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer.
// Saturation helpers are consumed only when CALC_SAT_EN is defined.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } seqStateT;

    localparam logic [2:0] OP_ADD_AB = 3'b000;
    localparam logic [2:0] OP_SUB_AB = 3'b001;
    localparam logic [2:0] OP_ABS_B  = 3'b010;
    localparam logic [2:0] OP_ADD_BA = 3'b100;
    localparam logic [2:0] OP_SUB_BA = 3'b101;
    localparam logic [2:0] OP_ABS_A  = 3'b110;

    // Bit patterns of the most positive / most negative w-bit signed values.
    function automatic logic [63:0] satMax(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] satMin(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/calc_sequencer_comb_calc.sv
// CombCalc: combinational W-bit two's-complement calculator with signed overflow flag.
// Opcode bit 0 is a don't-care for the two absolute-value operations.
module CombCalc
    import calc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] r,
    output logic         ovf
);

    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    always_comb begin
        r   = '0;
        ovf = 1'b0;
        casez (op)
            OP_ADD_AB: begin
                r   = a + b;
                ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_SUB_AB: begin
                r   = a - b;
                ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b01?: begin
                r   = b[W-1] ? -b : b;
                ovf = (b == MIN_VAL);
            end
            OP_ADD_BA: begin
                r   = b + a;
                ovf = (a[W-1] == b[W-1]) && (r[W-1] != b[W-1]);
            end
            OP_SUB_BA: begin
                r   = b - a;
                ovf = (b[W-1] != a[W-1]) && (r[W-1] != b[W-1]);
            end
            default: begin
                r   = a[W-1] ? -a : a;
                ovf = (a == MIN_VAL);
            end
        endcase
    end

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: turns CombCalc into a multi-cycle accumulate engine behind cmd/rsp handshakes.
// Define CALC_SAT_EN to saturate ACC on overflowing iterations instead of wrapping.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready=1
// RUN   | one calculator iteration per cycle until the count expires
// RESP  | holding the response until rsp_ready
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_load,
    input  logic [2:0]    cmd_op,
    input  logic [W-1:0]  cmd_data,
    input  logic [CW-1:0] cmd_cnt,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_data,
    output logic          rsp_ovf,
    output logic          busy
);

    seqStateT      state;
    seqStateT      stateNext;
    logic [W-1:0]  accReg;
    logic [W-1:0]  opndReg;
    logic [2:0]    opReg;
    logic [CW-1:0] cntReg;
    logic          ovfSticky;
    logic [W-1:0]  calcR;
    logic          calcOvf;
    logic [W-1:0]  accNext;

    CombCalc #(.W(W)) uCalc (
        .a   (accReg),
        .b   (opndReg),
        .op  (opReg),
        .r   (calcR),
        .ovf (calcOvf)
    );

`ifdef CALC_SAT_EN
    localparam logic [63:0]  SAT_MAX_FULL = satMax(W);
    localparam logic [63:0]  SAT_MIN_FULL = satMin(W);
    localparam logic [W-1:0] SAT_MAX      = SAT_MAX_FULL[W-1:0];
    localparam logic [W-1:0] SAT_MIN      = SAT_MIN_FULL[W-1:0];

    // A negative-looking wrapped result means we overflowed upwards.
    assign accNext = calcOvf ? (calcR[W-1] ? SAT_MAX : SAT_MIN) : calcR;
`else
    assign accNext = calcR;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    stateNext = (cmd_load || (cmd_cnt == '0)) ? RESP : RUN;
                end
            end
            RUN: begin
                if (cntReg == CW'(1)) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accReg    <= '0;
            opndReg   <= '0;
            opReg     <= OP_ADD_AB;
            cntReg    <= '0;
            ovfSticky <= 1'b0;
        end else if (state == IDLE && cmd_valid) begin
            opReg     <= cmd_op;
            opndReg   <= cmd_data;
            cntReg    <= cmd_cnt;
            ovfSticky <= 1'b0;
            if (cmd_load) begin
                accReg <= cmd_data;
            end
        end else if (state == RUN) begin
            accReg    <= accNext;
            ovfSticky <= ovfSticky | calcOvf;
            cntReg    <= cntReg - CW'(1);
        end
    end

    assign rsp_data = accReg;
    assign rsp_ovf  = ovfSticky;

endmodule

// File: tb/tb_calc_sequencer.sv
// Randomized self-checking bench for calc_sequencer against an integer-arithmetic model.
// Honours CALC_SAT_EN in the model so it checks either build.
module tb_calc_sequencer;

    localparam int W  = 16;
    localparam int CW = 4;
    localparam int S_MAX = (1 << (W - 1)) - 1;
    localparam int S_MIN = -(1 << (W - 1));

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_load = 1'b0;
    logic [2:0]    cmd_op = '0;
    logic [W-1:0]  cmd_data = '0;
    logic [CW-1:0] cmd_cnt = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_data;
    logic          rsp_ovf;
    logic          busy;

    int nCompared = 0;
    int nMismatched = 0;
    logic [W-1:0] mAcc = '0;

    always #5 clk = ~clk;

    calc_sequencer #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_cnt   (cmd_cnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Applies a command as plain signed integer arithmetic, range-checked against W bits.
    function automatic void modelCmd(input bit load, input logic [2:0] op, input logic [W-1:0] d,
                                     input int cnt, inout logic [W-1:0] acc, output bit ovf);
        ovf = 1'b0;
        if (load) begin
            acc = d;
        end else begin
            for (int i = 0; i < cnt; i++) begin
                int a = $signed(acc);
                int b = $signed(d);
                int full;
                bit o;
                logic [W-1:0] r;
                case (op)
                    3'd0:       full = a + b;
                    3'd1:       full = a - b;
                    3'd2, 3'd3: full = (b < 0) ? -b : b;
                    3'd4:       full = b + a;
                    3'd5:       full = b - a;
                    default:    full = (a < 0) ? -a : a;
                endcase
                o = (full > S_MAX) || (full < S_MIN);
                r = full[W-1:0];
`ifdef CALC_SAT_EN
                if (o) r = (full > S_MAX) ? W'(S_MAX) : W'(S_MIN);
`endif
                acc = r;
                ovf = ovf | o;
            end
        end
    endfunction

    task automatic doCmd(input bit load, input logic [2:0] op, input logic [W-1:0] d,
                         input int cnt, input int stall, input string tag);
        bit expOvf;
        int expLat;
        int lat;
        logic [W-1:0] gotD;
        logic gotO;
        modelCmd(load, op, d, cnt, mAcc, expOvf);
        expLat = (load || cnt == 0) ? 1 : cnt + 1;
        @(negedge clk);
        checkVal({tag, " cmd_ready idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_load  = load;
        cmd_op    = op;
        cmd_data  = d;
        cmd_cnt   = cnt[CW-1:0];
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = W'($urandom);
        cmd_op    = 3'($urandom);
        lat = 1;
        @(negedge clk);
        checkVal({tag, " cmd_ready busy"}, 32'(cmd_ready), 32'd0);
        checkVal({tag, " busy"}, 32'(busy), 32'd1);
        while (!rsp_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        checkVal({tag, " latency"}, 32'(lat), 32'(expLat));
        checkVal({tag, " rsp_data"}, 32'(rsp_data), 32'(mAcc));
        checkVal({tag, " rsp_ovf"}, 32'(rsp_ovf), 32'(expOvf));
        gotD = rsp_data;
        gotO = rsp_ovf;
        for (int i = 0; i < stall; i++) begin
            cmd_valid = 1'($urandom);
            cmd_load  = 1'b1;
            cmd_data  = W'($urandom);
            cmd_cnt   = CW'($urandom);
            @(negedge clk);
            checkVal({tag, " hold data"}, 32'(rsp_data), 32'(gotD));
            checkVal({tag, " hold ovf"}, 32'(rsp_ovf), 32'(gotO));
            checkVal({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
            checkVal({tag, " hold cmd_ready"}, 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        checkVal({tag, " rsp released"}, 32'(rsp_valid), 32'd0);
        checkVal({tag, " idle after rsp"}, 32'(busy), 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        checkVal({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkVal({tag, " rsp_data"}, 32'(rsp_data), 32'd0);
        checkVal({tag, " rsp_ovf"}, 32'(rsp_ovf), 32'd0);
        checkVal({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bit sawRsp;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;

        doCmd(1'b1, 3'b000, 16'd5, 0, 0, "load5");
        doCmd(1'b0, 3'b000, 16'd3, 4, 0, "add3x4");
        doCmd(1'b1, 3'b000, 16'h7FFF, 0, 0, "loadMax");
        doCmd(1'b0, 3'b000, 16'd1, 1, 0, "addOvf");
        doCmd(1'b0, 3'b001, 16'd0, 1, 0, "stickyClr");
        doCmd(1'b1, 3'b000, 16'h8000, 0, 0, "loadMin");
        doCmd(1'b0, 3'b110, 16'd0, 3, 0, "absMin");
        doCmd(1'b1, 3'b000, 16'd10, 0, 0, "load10");
        doCmd(1'b0, 3'b101, 16'd4, 2, 0, "subBA");
        doCmd(1'b0, 3'b000, 16'd0, 0, 0, "cnt0");
        doCmd(1'b0, 3'b000, 16'd7, 2, 6, "backpressure");

        // Reset in the middle of a long RUN.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_load  = 1'b0;
        cmd_op    = 3'b000;
        cmd_data  = 16'd1;
        cmd_cnt   = 4'd8;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("midrun busy", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("async reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mAcc = '0;
        sawRsp = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) sawRsp = 1'b1;
        end
        checkVal("no rsp after reset", 32'(sawRsp), 32'd0);
        doCmd(1'b0, 3'b000, 16'd1, 1, 0, "postReset");

        for (int n = 0; n < 60; n++) begin
            bit ld;
            ld = ($urandom_range(0, 3) == 0);
            doCmd(ld, 3'($urandom), W'($urandom), $urandom_range(0, 15),
                  $urandom_range(0, 3), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
